// File: rtl/tank_bullet.sv
// Per-tank projectile engine: spawns one bullet ahead of the tank,
// advances it on the frame tick, retires it and runs a reload cooldown.
module tank_bullet #(
  parameter int MAP_X_MAX    = 39,
  parameter int MAP_Y_MAX    = 29,
  parameter int SPEED_DIV    = 2,
  parameter int RELOAD_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [5:0] tank_x_pos,
  input  logic [5:0] tank_y_pos,
  input  logic [1:0] tank_dir,
  input  logic       hit,
  output logic       fire_ready,
  output logic       bullet_valid,
  output logic [5:0] bullet_x,
  output logic [5:0] bullet_y,
  output logic [1:0] bullet_dir
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  localparam logic [5:0] XMAX     = 6'(MAP_X_MAX);
  localparam logic [5:0] YMAX     = 6'(MAP_Y_MAX);
  localparam logic [3:0] DIV_LAST = 4'(SPEED_DIV - 1);
  localparam logic [7:0] CNT_LAST = 8'(RELOAD_TICKS - 1);

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [5:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [1:0]  dir_q, dir_d;
  logic [3:0]  div_q, div_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        sp_ok, mv_ok;
  logic [5:0]  sp_x, sp_y, mv_x, mv_y;

  // Edge test happens before the add/sub so a wrapped value is never used.
  function automatic logic [12:0] adv(input logic [5:0] x,
                                      input logic [5:0] y,
                                      input logic [1:0] d);
    logic       ok;
    logic [5:0] nx, ny;
    ok = 1'b1;
    nx = x;
    ny = y;
    unique case (d)
      2'd0: begin ok = (y != 6'd0); ny = y - 6'd1; end
      2'd1: begin ok = (y != YMAX); ny = y + 6'd1; end
      2'd2: begin ok = (x != 6'd0); nx = x - 6'd1; end
      2'd3: begin ok = (x != XMAX); nx = x + 6'd1; end
    endcase
    return {ok, nx, ny};
  endfunction

  assign {sp_ok, sp_x, sp_y} = adv(tank_x_pos, tank_y_pos, tank_dir);
  assign {mv_ok, mv_x, mv_y} = adv(x_q, y_q, dir_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (sp_ok) begin
            state_d = FLY;
            valid_d = 1'b1;
            x_d     = sp_x;
            y_d     = sp_y;
            dir_d   = tank_dir;
            div_d   = '0;
          end else begin
            state_d = COOL;
            cnt_d   = '0;
          end
        end
      end
      FLY: begin
        if (hit) begin
          state_d = COOL;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (frame_tick) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (mv_ok) begin
              x_d = mv_x;
              y_d = mv_y;
            end else begin
              state_d = COOL;
              valid_d = 1'b0;
              cnt_d   = '0;
            end
          end else begin
            div_d = div_q + 4'd1;
          end
        end
      end
      COOL: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fire_ready   = (state_q == IDLE);
    bullet_valid = valid_q;
    bullet_x     = x_q;
    bullet_y     = y_q;
    bullet_dir   = dir_q;
  end

endmodule

// File: tb/tb_tank_bullet.sv
// Directed bench for tank_bullet: expectations are queued per step
// and checked against the outputs 1ns after the clock edge.
module tb_tank_bullet;

  logic       clk = 1'b0;
  logic       rst, frame_tick, fire, hit;
  logic [5:0] tank_x_pos, tank_y_pos;
  logic [1:0] tank_dir;
  logic       fire_ready, bullet_valid;
  logic [5:0] bullet_x, bullet_y;
  logic [1:0] bullet_dir;

  int ncmp = 0;
  int nerr = 0;

  logic [15:0] expq[$];
  string       tagq[$];

  tank_bullet #(
    .MAP_X_MAX   (39),
    .MAP_Y_MAX   (29),
    .SPEED_DIV   (2),
    .RELOAD_TICKS(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .fire        (fire),
    .tank_x_pos  (tank_x_pos),
    .tank_y_pos  (tank_y_pos),
    .tank_dir    (tank_dir),
    .hit         (hit),
    .fire_ready  (fire_ready),
    .bullet_valid(bullet_valid),
    .bullet_x    (bullet_x),
    .bullet_y    (bullet_y),
    .bullet_dir  (bullet_dir)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic f, input logic t,
                      input logic h, input logic ev, input logic [5:0] ex,
                      input logic [5:0] ey, input logic [1:0] ed,
                      input logic er);
    logic [15:0] obs, e;
    string       tg;
    fire       = f;
    frame_tick = t;
    hit        = h;
    expq.push_back({ev, ex, ey, ed, er});
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    while (expq.size() > 0) begin
      e   = expq.pop_front();
      tg  = tagq.pop_front();
      obs = {bullet_valid, bullet_x, bullet_y, bullet_dir, fire_ready};
      ncmp++;
      assert (obs === e) else begin
        nerr++;
        $error("FAIL %s: observed v=%0b x=%0d y=%0d d=%0d rdy=%0b expected v=%0b x=%0d y=%0d d=%0d rdy=%0b",
               tg, obs[15], obs[14:9], obs[8:3], obs[2:1], obs[0],
               e[15], e[14:9], e[8:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic cool8(input string tag, input logic f, input logic [5:0] x,
                       input logic [5:0] y, input logic [1:0] d);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) step({tag, "_ign"}, 1'b1, 1'b0, 1'b1, 1'b0, x, y, d, 1'b0);
      step(tag, f, 1'b1, 1'b0, 1'b0, x, y, d, (i == 7));
    end
  endtask

  task automatic tank(input logic [5:0] x, input logic [5:0] y,
                      input logic [1:0] d);
    tank_x_pos = x;
    tank_y_pos = y;
    tank_dir   = d;
  endtask

  initial begin
    rst = 1'b1;
    tank(6'd10, 6'd10, 2'd3);
    step("reset", 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 2'd0, 1'b1);
    rst = 1'b0;

    step("spawn_r", 1, 0, 0, 1, 6'd11, 6'd10, 2'd3, 0);
    step("t1", 0, 1, 0, 1, 6'd11, 6'd10, 2'd3, 0);
    step("t2", 0, 1, 0, 1, 6'd12, 6'd10, 2'd3, 0);
    tank(6'd10, 6'd10, 2'd0);
    step("t3_fire_ign", 1, 1, 0, 1, 6'd12, 6'd10, 2'd3, 0);
    step("t4", 0, 1, 0, 1, 6'd13, 6'd10, 2'd3, 0);
    step("t5", 0, 1, 0, 1, 6'd13, 6'd10, 2'd3, 0);
    step("hit_tick", 0, 1, 1, 0, 6'd13, 6'd10, 2'd3, 0);
    cool8("cool_hit", 0, 6'd13, 6'd10, 2'd3);

    tank(6'd5, 6'd0, 2'd0);
    step("offmap_up", 1, 0, 0, 0, 6'd13, 6'd10, 2'd3, 0);
    cool8("cool_up", 0, 6'd13, 6'd10, 2'd3);

    tank(6'd37, 6'd3, 2'd3);
    step("spawn_edge", 1, 0, 0, 1, 6'd38, 6'd3, 2'd3, 0);
    step("edge_t1", 0, 1, 0, 1, 6'd38, 6'd3, 2'd3, 0);
    step("edge_t2", 0, 1, 0, 1, 6'd39, 6'd3, 2'd3, 0);
    step("edge_t3", 0, 1, 0, 1, 6'd39, 6'd3, 2'd3, 0);
    step("edge_exit", 0, 1, 0, 0, 6'd39, 6'd3, 2'd3, 0);
    cool8("cool_exit", 0, 6'd39, 6'd3, 2'd3);

    tank(6'd1, 6'd5, 2'd2);
    step("spawn_left", 1, 0, 0, 1, 6'd0, 6'd5, 2'd2, 0);
    step("left_t1", 0, 1, 0, 1, 6'd0, 6'd5, 2'd2, 0);
    step("left_exit", 0, 1, 0, 0, 6'd0, 6'd5, 2'd2, 0);
    cool8("cool_left", 0, 6'd0, 6'd5, 2'd2);

    tank(6'd4, 6'd29, 2'd1);
    step("offmap_dn", 1, 0, 0, 0, 6'd0, 6'd5, 2'd2, 0);
    cool8("cool_dn", 0, 6'd0, 6'd5, 2'd2);

    tank(6'd36, 6'd7, 2'd3);
    step("auto_spawn", 1, 0, 0, 1, 6'd37, 6'd7, 2'd3, 0);
    step("auto_t1", 1, 1, 0, 1, 6'd37, 6'd7, 2'd3, 0);
    step("auto_t2", 1, 1, 0, 1, 6'd38, 6'd7, 2'd3, 0);
    step("auto_t3", 1, 1, 0, 1, 6'd38, 6'd7, 2'd3, 0);
    step("auto_t4", 1, 1, 0, 1, 6'd39, 6'd7, 2'd3, 0);
    step("auto_t5", 1, 1, 0, 1, 6'd39, 6'd7, 2'd3, 0);
    step("auto_exit", 1, 1, 0, 0, 6'd39, 6'd7, 2'd3, 0);
    cool8("cool_auto", 1, 6'd39, 6'd7, 2'd3);
    step("auto_respawn", 1, 0, 0, 1, 6'd37, 6'd7, 2'd3, 0);
    step("auto_hold", 1, 0, 0, 1, 6'd37, 6'd7, 2'd3, 0);

    tank(6'd19, 6'd20, 2'd3);
    rst = 1'b1;
    step("rst_fly", 1, 1, 0, 0, 6'd0, 6'd0, 2'd0, 1);
    rst = 1'b0;
    tank(6'd20, 6'd20, 2'd1);
    step("post_rst", 1, 0, 0, 1, 6'd20, 6'd21, 2'd1, 0);
    step("down_t1", 0, 1, 0, 1, 6'd20, 6'd21, 2'd1, 0);
    step("down_t2", 0, 1, 0, 1, 6'd20, 6'd22, 2'd1, 0);
    step("hit_notick", 0, 0, 1, 0, 6'd20, 6'd22, 2'd1, 0);
    rst = 1'b1;
    step("rst_cool", 0, 0, 0, 0, 6'd0, 6'd0, 2'd0, 1);
    rst = 1'b0;
    tank(6'd8, 6'd9, 2'd0);
    step("spawn_up", 1, 0, 0, 1, 6'd8, 6'd8, 2'd0, 0);
    step("up_t1", 0, 1, 0, 1, 6'd8, 6'd8, 2'd0, 0);
    step("up_t2", 0, 1, 0, 1, 6'd8, 6'd7, 2'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
